// File: rtl/fwd_scoreboard_unit_pkg.sv
// fwd_pkg: forwarding-select codes and pipeline-entry geometry shared by the scoreboard.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WBBYP = 2'b11;

    localparam int SEL_W          = 2;
    localparam int NUM_STAGES     = 4;
    localparam int NUM_FWD_STAGES = NUM_STAGES - 1;
    localparam int ZERO_REG_DEF   = 31;

endpackage

// File: rtl/fwd_scoreboard_unit_operand_select.sv
// fwd_operand_select: youngest-first forwarding match for one source operand over stages 1..3.
module fwd_operand_select
    import fwd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int WB_BYPASS = 1,
    parameter int ZERO_REG  = ZERO_REG_DEF
) (
    input  logic [REG_AW-1:0]                rs,
    input  logic [DATA_W-1:0]                rf_data,
    input  logic [NUM_FWD_STAGES-1:0]        st_valid,
    input  logic [NUM_FWD_STAGES-1:0]        st_regwrite,
    input  logic                             ex_mem_is_load,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] st_rd,
    input  logic [NUM_FWD_STAGES*DATA_W-1:0] st_data,
    output logic [SEL_W-1:0]                 sel,
    output logic [DATA_W-1:0]                data,
    output logic                             load_hit
);

    logic [NUM_FWD_STAGES-1:0] hit;

    // bit 0 = EX/MEM, bit 1 = MEM/WB, bit 2 = WB-bypass
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_FWD_STAGES; k++)
            hit[k] = st_valid[k] && st_regwrite[k] && st_rd[k*REG_AW +: REG_AW] == rs
                     && rs != REG_AW'(ZERO_REG);
        hit[2] = hit[2] && (WB_BYPASS != 0);
        sel = hit[0] ? FWD_EXMEM : hit[1] ? FWD_MEMWB : hit[2] ? FWD_WBBYP : FWD_RF;
        data = hit[0] ? st_data[0 +: DATA_W] :
               hit[1] ? st_data[DATA_W +: DATA_W] :
               hit[2] ? st_data[2*DATA_W +: DATA_W] : rf_data;
        load_hit = hit[0] && ex_mem_is_load;
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: in-flight write tracking, operand forwarding, load-use stall and stall counting.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int WB_BYPASS = 1,
    parameter int ZERO_REG  = ZERO_REG_DEF,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_regwrite,
    input  logic                        id_memread,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           ex_alu_result,
    input  logic [DATA_W-1:0]           mem_load_data,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_data,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall_out,
    output logic [CNT_W-1:0]            stall_count
);

    // Stage 0 = EX, 1 = EX/MEM, 2 = MEM/WB, 3 = WB-bypass; stage 0 carries no data yet.
    logic [NUM_STAGES-1:0]                 valid_q, valid_d;
    logic [NUM_STAGES-1:0]                 rw_q, rw_d;
    logic [1:0]                            ld_q, ld_d;
    logic [NUM_STAGES-1:0][REG_AW-1:0]     rd_q, rd_d;
    logic [NUM_STAGES-1:1][DATA_W-1:0]     data_q, data_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_SRC-1:0]                    load_hit;
    logic                                  stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_operand_select #(
            .DATA_W   (DATA_W),
            .REG_AW   (REG_AW),
            .WB_BYPASS(WB_BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .rs            (ex_rs[i*REG_AW +: REG_AW]),
            .rf_data       (ex_rf_data[i*DATA_W +: DATA_W]),
            .st_valid      (valid_q[3:1]),
            .st_regwrite   (rw_q[3:1]),
            .ex_mem_is_load(ld_q[1]),
            .st_rd         (rd_q[3:1]),
            .st_data       (data_q),
            .sel           (fwd_sel[i*SEL_W +: SEL_W]),
            .data          (fwd_data[i*DATA_W +: DATA_W]),
            .load_hit      (load_hit[i])
        );
    end

    always_comb begin
        stall = !flush && valid_q[0] && |load_hit;
        cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        valid_d[3] = valid_q[2] && (WB_BYPASS != 0);
        rw_d[3] = rw_q[2];
        rd_d[3] = rd_q[2];
        data_d[3] = data_q[2];
        valid_d[2] = valid_q[1];
        rw_d[2] = rw_q[1];
        rd_d[2] = rd_q[1];
        data_d[2] = ld_q[1] ? mem_load_data : data_q[1];
        // A stalled or flushed EX instruction leaves a bubble behind it.
        valid_d[1] = valid_q[0] && !stall && !flush;
        rw_d[1] = rw_q[0];
        ld_d[1] = ld_q[0];
        rd_d[1] = rd_q[0];
        data_d[1] = ex_alu_result;
        valid_d[0] = stall ? valid_q[0] : id_valid;
        rw_d[0] = stall ? rw_q[0] : id_regwrite;
        ld_d[0] = stall ? ld_q[0] : id_memread;
        rd_d[0] = stall ? rd_q[0] : id_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            rw_q <= '0;
            ld_q <= '0;
            rd_q <= '0;
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q <= rw_d;
            ld_q <= ld_d;
            rd_q <= rd_d;
            data_q <= data_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_out = stall;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb_fwd_scoreboard_unit: directed pipeline scenarios with a queue-based expected-output scoreboard.
module tb_fwd_scoreboard_unit;

    localparam int M_SEL = 1, M_DAT = 2, M_ST = 4, M_CNT = 8, M_ALL = 15;

    logic clk, reset, id_valid, id_regwrite, id_memread, flush;
    logic [4:0] id_rd;
    logic [63:0] ex_alu_result, mem_load_data;
    logic [9:0] ex_rs;
    logic [127:0] ex_rf_data, fwd_data;
    logic [3:0] fwd_sel;
    logic stall_out;
    logic [3:0] stall_count;

    typedef struct {
        string nm;
        logic [3:0] mask;
        logic [3:0] sel;
        logic [127:0] data;
        logic stall;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int n_chk = 0;
    int n_pass = 0;

    fwd_scoreboard_unit #(
        .DATA_W(64), .REG_AW(5), .NUM_SRC(2), .WB_BYPASS(1), .ZERO_REG(31), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ex_alu_result(ex_alu_result), .mem_load_data(mem_load_data),
        .ex_rs(ex_rs), .ex_rf_data(ex_rf_data), .fwd_data(fwd_data),
        .fwd_sel(fwd_sel), .stall_out(stall_out), .stall_count(stall_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rf(input logic [4:0] r);
        return 64'h1000 + 64'(r);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    // Monitor: pops one expectation per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.mask[0]) chk({cur.nm, " sel"}, 128'(fwd_sel), 128'(cur.sel));
            if (cur.mask[1]) chk({cur.nm, " data"}, fwd_data, cur.data);
            if (cur.mask[2]) chk({cur.nm, " stall"}, 128'(stall_out), 128'(cur.stall));
            if (cur.mask[3]) chk({cur.nm, " count"}, 128'(stall_count), 128'(cur.cnt));
        end
    end

    task automatic drive(input logic iv, input logic [4:0] ird, input logic irw, input logic ild,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [63:0] alu, input logic [63:0] mld, input logic fl);
        id_valid = iv;
        id_rd = ird;
        id_regwrite = irw;
        id_memread = ild;
        ex_rs = {r1, r0};
        ex_rf_data = {rf(r1), rf(r0)};
        ex_alu_result = alu;
        mem_load_data = mld;
        flush = fl;
    endtask

    task automatic push_exp(input string nm, input logic [3:0] mask, input logic [1:0] s0,
                            input logic [1:0] s1, input logic [63:0] d0, input logic [63:0] d1,
                            input logic st, input logic [3:0] c);
        exp_t e;
        e.nm = nm;
        e.mask = mask;
        e.sel = {s1, s0};
        e.data = {d1, d0};
        e.stall = st;
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 1, 2, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1;
        drive(0, 0, 0, 0, 1, 2, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Empty pipeline: everything from the register file.
        drive(0, 0, 0, 0, 2, 3, 0, 0, 0);
        push_exp("reset", M_ALL, 2'b00, 2'b00, rf(2), rf(3), 0, 0);
        tick();

        // ADD X5 (0x10), then SUB X6 reading X5.
        drive(1, 5, 1, 0, 1, 2, 0, 0, 0); tick();
        drive(1, 6, 1, 0, 1, 2, 64'h10, 0, 0); tick();
        drive(0, 0, 0, 0, 5, 2, 64'h99, 0, 0);
        push_exp("exmem fwd", M_ALL, 2'b10, 2'b00, 64'h10, rf(2), 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 2, 0, 0, 0);
        push_exp("memwb fwd", M_ALL, 2'b01, 2'b00, 64'h10, rf(2), 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 6, 0, 0, 0);
        push_exp("wbbyp+memwb", M_SEL | M_DAT, 2'b11, 2'b01, 64'h10, 64'h99, 0, 0);
        tick();
        nop(4);

        // LDUR X7, then ADD X8,X7,X7: one stall, then forwarding from MEM/WB.
        drive(1, 7, 1, 1, 1, 2, 0, 0, 0); tick();
        drive(1, 8, 1, 0, 1, 2, 64'h500, 0, 0); tick();
        drive(1, 9, 1, 0, 7, 7, 0, 64'hDEAD_BEEF, 0);
        push_exp("load-use", M_ALL, 2'b10, 2'b10, 64'h500, 64'h500, 1, 0);
        tick();
        drive(0, 0, 0, 0, 7, 7, 64'h77, 0, 0);
        push_exp("after stall", M_ALL, 2'b01, 2'b01, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 1);
        tick();
        nop(4);

        // Load writing XZR must never forward or stall; regwrite=0 never forwards.
        drive(1, 31, 1, 1, 1, 2, 0, 0, 0); tick();
        drive(1, 10, 0, 0, 1, 2, 64'h31, 0, 0); tick();
        drive(1, 9, 0, 1, 31, 31, 0, 0, 0);
        push_exp("xzr", M_ALL, 2'b00, 2'b00, rf(31), rf(31), 0, 1);
        tick();
        drive(1, 11, 0, 0, 1, 2, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 9, 9, 0, 0, 0);
        push_exp("regwrite0", M_ALL, 2'b00, 2'b00, rf(9), rf(9), 0, 1);
        tick();
        nop(4);

        // X4 in EX/MEM (0xA) and MEM/WB (0xB): youngest wins.
        drive(1, 4, 1, 0, 1, 2, 0, 0, 0); tick();
        drive(1, 4, 1, 0, 1, 2, 64'hB, 0, 0); tick();
        drive(1, 12, 1, 0, 1, 2, 64'hA, 0, 0); tick();
        drive(0, 0, 0, 0, 4, 3, 64'h55, 0, 0);
        push_exp("priority 1>2", M_SEL | M_DAT, 2'b10, 2'b00, 64'hA, rf(3), 0, 0);
        tick();
        drive(0, 0, 0, 0, 4, 4, 0, 0, 0);
        push_exp("priority 2>3", M_SEL | M_DAT, 2'b01, 2'b01, 64'hA, 64'hA, 0, 0);
        tick();
        nop(4);

        // X4 only in the WB-bypass stage.
        drive(1, 4, 1, 0, 1, 2, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 2, 64'hC, 0, 0); tick();
        nop(2);
        drive(0, 0, 0, 0, 3, 4, 0, 0, 0);
        push_exp("wb bypass", M_SEL | M_DAT, 2'b00, 2'b11, rf(3), 64'hC, 0, 0);
        tick();
        nop(4);

        // Load-use with flush in the same cycle: no stall, EX instruction discarded.
        drive(1, 7, 1, 1, 1, 2, 0, 0, 0); tick();
        drive(1, 8, 1, 0, 1, 2, 64'h600, 0, 0); tick();
        drive(0, 0, 0, 0, 7, 7, 0, 64'h1234, 1);
        push_exp("flush", M_ALL, 2'b10, 2'b10, 64'h600, 64'h600, 0, 1);
        tick();
        drive(0, 0, 0, 0, 8, 7, 0, 0, 0);
        push_exp("flush bubble", M_ALL, 2'b00, 2'b01, rf(8), 64'h1234, 0, 1);
        tick();
        nop(4);

        // Reset asserted on a stall cycle.
        drive(1, 7, 1, 1, 1, 2, 0, 0, 0); tick();
        drive(1, 8, 1, 0, 1, 2, 64'h700, 0, 0); tick();
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
        reset = 1;
        push_exp("pre-reset stall", M_ALL, 2'b10, 2'b10, 64'h700, 64'h700, 1, 1);
        tick();
        reset = 0;
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
        push_exp("mid reset", M_ALL, 2'b00, 2'b00, rf(7), rf(7), 0, 0);
        tick();

        // Back-to-back self-dependent loads: a stall every other cycle, counter saturates.
        drive(1, 7, 1, 1, 7, 7, 0, 0, 0); tick();
        for (int j = 0; j < 42; j++) begin
            drive(1, 7, 1, 1, 7, 7, 64'(j), 64'(j), 0);
            push_exp($sformatf("sat %0d", j), M_ST | M_CNT, 0, 0, 0, 0, j[0],
                     (j / 2 > 15) ? 4'hF : 4'(j / 2));
            tick();
        end
        drive(0, 0, 0, 0, 7, 7, 0, 0, 0);
        push_exp("saturated", M_ST | M_CNT, 0, 0, 0, 0, 0, 4'hF);
        tick();

        nop(2);
        chk("scoreboard drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised successor to the single-operand ALU forwarding mux in the five-stage LEGv8 pipeline.
- Tracks in-flight register writes in EX, EX/MEM, MEM/WB and an optional WB-bypass stage.
- Resolves forwarding for NUM_SRC operands of the instruction in EX.
- Detects load-use hazards, stalls with bubble insertion, accepts branch flushes, and counts stall cycles.

Parameters:
- DATA_W, 64, operand/result width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands forwarded (1..4).
- WB_BYPASS, 1, 1 = keep a stage-3 entry so write-then-read in the same cycle is forwarded; 0 = no stage 3.
- ZERO_REG, 31, register that is never forwarded (XZR).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID/EX is loading a real instruction this cycle
- id_rd  in  REG_AW  its destination register
- id_regwrite  in  1  it writes the register file
- id_memread  in  1  it is a load
- flush  in  1  invalidate the instruction currently in EX (branch taken)
- ex_alu_result  in  DATA_W  ALU result of the EX instruction
- mem_load_data  in  DATA_W  load data of the EX/MEM instruction
- ex_rs  in  NUM_SRC*REG_AW  source register numbers of the EX instruction
- ex_rf_data  in  NUM_SRC*DATA_W  register-file operand values
- fwd_data  out  NUM_SRC*DATA_W  resolved operands
- fwd_sel  out  NUM_SRC*2  per operand: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 WB-bypass
- stall_out  out  1  freeze PC, IF/ID and ID/EX
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry fields: valid, rd, regwrite, is_load, data. Stage 0 = EX, 1 = EX/MEM, 2 = MEM/WB, 3 = WB-bypass.
- Reset: all entries invalid; stall_count = 0. Outputs then give fwd_sel = 00, fwd_data = ex_rf_data, stall_out = 0.
- Match for operand i at stage k (k >= 1): entry valid, regwrite set, rd == rs_i, and rs_i != ZERO_REG.
- Priority: youngest stage wins, in the order 1, 2, 3. Stage 3 is ignored when WB_BYPASS = 0.
- fwd_data output: stage 1 gives stage1.data, stage 2 gives stage2.data, stage 3 gives stage3.data; no match gives ex_rf_data.
- Load-use stall:
  - stall_out = 1 when stage 0 is valid and, for any operand, the highest-priority match is stage 1 with is_load = 1.
  - flush forces stall_out = 0.
  - stall_out is combinational from registered state plus ex_rs.
- Normal advance (stall_out = 0) at each clock:
  - stage3 <= stage2
  - stage2 <= stage1, with data = stage1.is_load ? mem_load_data : stage1.data
  - stage1 <= stage0, with data = ex_alu_result
  - stage0 <= id_* fields, with valid = id_valid
- Stall cycle:
  - stage0 holds.
  - stage1 <= bubble (valid = 0).
  - stages 2 and 3 shift as in normal advance, so the load data lands in stage 2.
  - Next cycle the operand forwards from stage 2 with sel 01, one stall per load-use.
- flush: stage1 <= bubble (EX instruction discarded); stage0 <= id_* as normal. flush and stall together: flush wins and no stall is counted.
- stall_count increments on each stall_out = 1 cycle and saturates at all-ones.
- Reset mid-operation: clears all entries and stall_count in the same edge. Any pending stall is dropped.
- Stall latency: zero cycles, combinational on the hazard cycle. Forward latency: zero cycles.

Decomposition:
- Shared package fwd_pkg holds:
  - constants FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10, FWD_WBBYP = 2'b11
  - an entry struct/field-width localparams
  - the ZERO_REG default
- Sub-module fwd_operand_select: one per operand, via generate.
  - Pure priority match over stages 1..3.
  - Returns sel, data and a load_hit flag.
- The top level holds the stage registers, the stall logic and the counter.

Test Plan:
- Reset, then ex_rs = {2,3}, no in-flight entries → fwd_sel = 00/00, fwd_data = ex_rf_data, stall_out = 0, stall_count = 0.
- ADD X5 (alu 0x10) then SUB using X5 in the next cycle → operand 0 sel 10, data 0x10. Two cycles later (X5 in MEM/WB) → sel 01, data 0x10.
- LDUR X7 then ADD X8,X7,X7 immediately:
  - one cycle stall_out = 1 with both operands hazarded;
  - next cycle sel 01/01, data = mem_load_data 0xDEAD_BEEF;
  - stall_count = 1.
- Write X31 in EX/MEM and read X31 → sel 00, no stall. Same instruction writing X9 with regwrite = 0 → sel 00.
- X4 in both EX/MEM (0xA) and MEM/WB (0xB) → sel 10, data 0xA. WB_BYPASS = 1 with X4 only in stage 3 (0xC) → sel 11, data 0xC.
- Load-use hazard with flush asserted in the same cycle → stall_out = 0, stall_count unchanged, stage1 bubble.
- Reset asserted mid-stall → next cycle stall_out = 0, stall_count = 0.
- Stall counter preset near all-ones (CNT_W = 4) across 20 stalls → holds at 0xF.
